// File: rtl/spi_fifo_pkg.sv
// Shared definitions for the FIFO-buffered SPI master: register map, STATUS/IMASK
// bit positions and the shifter FSM states.
package spi_fifo_pkg;
  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_DIV    = 3'd2;
  localparam logic [2:0] REG_CS     = 3'd3;
  localparam logic [2:0] REG_IMASK  = 3'd4;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_BUSY     = 4;
  localparam int ST_CS_PEND  = 5;
  localparam int ST_TX_ERR   = 6;

  localparam int IM_TX_EMPTY = 0;
  localparam int IM_RX_NE    = 1;
  localparam int IM_IDLE     = 2;

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} spi_state_e;
endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra bit so that
// full and empty are distinguishable. Pushes while full are discarded.
module spi_sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0] r_mem [2**AW];
  logic [AW:0]  r_wp, r_rp;
  logic         w_push, w_pop;

  // Full is judged on the pre-pop count, so a push into a full FIFO drops.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign count  = r_wp - r_rp;
  assign full   = count[AW];
  assign empty  = (count == '0);
  assign dout   = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/spi_fifo_master.sv
// Memory-mapped SPI master (mode 0, MSB first) with TX/RX FIFOs, SCK divider and
// deferred chip-select update. Define SPI_IRQ_EN to build the maskable interrupt.
module spi_fifo_master
  import spi_fifo_pkg::*;
#(
  parameter int TX_AW   = 3,
  parameter int RX_AW   = 3,
  parameter int NCS     = 2,
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 63
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           ce,
  input  logic [2:0]     addr,
  input  logic [7:0]     wdata,
  output logic [7:0]     rdata,
  input  logic           wr,
  input  logic           rd,
  output logic           sck,
  output logic           mosi,
  input  logic           miso,
  output logic [NCS-1:0] cs_n,
  output logic           irq
);
  logic             w_wr, w_rd;
  logic             w_tx_pop, w_tx_full, w_tx_empty;
  logic             w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [7:0]       w_tx_dout, w_rx_dout, w_status;
  logic [TX_AW:0]   w_unused_txcnt;
  logic [RX_AW:0]   w_unused_rxcnt;

  logic [DIV_W-1:0] r_div;
  logic [NCS-1:0]   r_cs_pend, r_cs;
  logic             r_cs_pending, r_tx_err;
  logic             w_cs_apply;

  spi_state_e       r_state, w_state_n;
  logic [DIV_W-1:0] r_cnt, w_cnt_n;
  logic [2:0]       r_bit, w_bit_n;
  logic [7:0]       r_txsh, w_txsh_n, r_rxsh, w_rxsh_n;
  logic             r_sck, w_sck_n, r_mosi, w_mosi_n;

  assign w_wr     = ce & wr;
  assign w_rd     = ce & rd;
  assign w_rx_pop = w_rd && (addr == REG_DATA);

  spi_sync_fifo #(.W(8), .AW(TX_AW)) u_tx (
    .clk(clk), .reset_n(reset_n),
    .push(w_wr && (addr == REG_DATA)), .pop(w_tx_pop), .din(wdata), .dout(w_tx_dout),
    .full(w_tx_full), .empty(w_tx_empty), .count(w_unused_txcnt)
  );

  spi_sync_fifo #(.W(8), .AW(RX_AW)) u_rx (
    .clk(clk), .reset_n(reset_n),
    .push(w_rx_push), .pop(w_rx_pop), .din(r_rxsh), .dout(w_rx_dout),
    .full(w_rx_full), .empty(w_rx_empty), .count(w_unused_rxcnt)
  );

  // Register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div        <= DIV_W'(DIV_RST);
      r_cs_pend    <= '0;
      r_cs_pending <= 1'b0;
      r_cs         <= '0;
      r_tx_err     <= 1'b0;
    end else begin
      if (w_wr && addr == REG_DIV) r_div <= DIV_W'(wdata);
      if (w_wr && addr == REG_CS) begin
        r_cs_pend    <= wdata[NCS-1:0];
        r_cs_pending <= 1'b1;
      end else if (w_cs_apply) begin
        r_cs_pending <= 1'b0;
      end
      if (w_cs_apply) r_cs <= r_cs_pend;
      if (w_wr && addr == REG_DATA && w_tx_full) r_tx_err <= 1'b1;
      else if (w_wr && addr == REG_STATUS)      r_tx_err <= 1'b0;
    end
  end

  // Shifter / divider FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_txsh  <= '0;
      r_rxsh  <= '0;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_txsh  <= w_txsh_n;
      r_rxsh  <= w_rxsh_n;
      r_sck   <= w_sck_n;
      r_mosi  <= w_mosi_n;
    end
  end

  // Each half period is DIV+1 clocks; the divider reloads from r_div at every edge.
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_bit_n    = r_bit;
    w_txsh_n   = r_txsh;
    w_rxsh_n   = r_rxsh;
    w_sck_n    = r_sck;
    w_mosi_n   = r_mosi;
    w_tx_pop   = 1'b0;
    w_rx_push  = 1'b0;
    w_cs_apply = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_cs_pending && w_tx_empty) begin
          w_cs_apply = 1'b1;
        end else if (!w_tx_empty && !w_rx_full) begin
          w_tx_pop  = 1'b1;
          w_txsh_n  = w_tx_dout;
          w_mosi_n  = w_tx_dout[7];
          w_cnt_n   = r_div;
          w_bit_n   = '0;
          w_state_n = S_LOW;
        end
      end
      S_LOW: begin
        if (r_cnt == '0) begin
          w_sck_n   = 1'b1;
          w_rxsh_n  = {r_rxsh[6:0], miso};
          w_cnt_n   = r_div;
          w_state_n = S_HIGH;
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      S_HIGH: begin
        if (r_cnt == '0) begin
          w_sck_n = 1'b0;
          w_cnt_n = r_div;
          if (r_bit == 3'd7) begin
            w_state_n = S_DONE;
          end else begin
            w_bit_n   = r_bit + 1'b1;
            w_txsh_n  = {r_txsh[6:0], 1'b0};
            w_mosi_n  = r_txsh[6];
            w_state_n = S_LOW;
          end
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      S_DONE: begin
        w_rx_push = 1'b1;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign sck  = r_sck;
  assign mosi = r_mosi;
  assign cs_n = ~r_cs;

  always_comb begin
    w_status              = '0;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_RX_EMPTY] = w_rx_empty;
    w_status[ST_RX_FULL]  = w_rx_full;
    w_status[ST_BUSY]     = (r_state != S_IDLE);
    w_status[ST_CS_PEND]  = r_cs_pending;
    w_status[ST_TX_ERR]   = r_tx_err;
  end

`ifdef SPI_IRQ_EN
  logic [2:0] r_imask, w_cond;
  logic       r_irq;

  always_comb begin
    w_cond              = '0;
    w_cond[IM_TX_EMPTY] = w_tx_empty;
    w_cond[IM_RX_NE]    = ~w_rx_empty;
    w_cond[IM_IDLE]     = (r_state == S_IDLE) & w_tx_empty;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_imask <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr && addr == REG_IMASK) r_imask <= wdata[2:0];
      r_irq <= |(r_imask & w_cond);
    end
  end
  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = 8'hFF;
    case (addr)
      REG_DATA:   rdata = w_rx_empty ? 8'hFF : w_rx_dout;
      REG_STATUS: rdata = w_status;
      REG_DIV:    rdata = 8'(r_div);
      REG_CS:     rdata = 8'(r_cs_pend);
`ifdef SPI_IRQ_EN
      REG_IMASK:  rdata = {5'd0, r_imask};
`endif
      default:    rdata = 8'hFF;
    endcase
  end
endmodule

// File: tb/tb_spi_fifo_master.sv
// Bench for spi_fifo_master: register-map vector table, then scoreboard-checked
// transfers covering timing, overflow, RX stall, CS deferral and IRQ.
module tb_spi_fifo_master;
  import spi_fifo_pkg::*;

  logic       clk = 1'b0, reset_n = 1'b0;
  logic       ce = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] wdata = '0, rdata;
  logic       sck, mosi, miso, irq;
  logic [1:0] cs_n;
  logic       loop_en = 1'b1, miso_c = 1'b1;

  int         n_vec = 0, n_err = 0;
  int         sck_pulses = 0;
  logic [7:0] sb[$];

`ifdef SPI_IRQ_EN
  localparam logic [7:0] IM_RST = 8'h00, IM_RB = 8'h05;
`else
  localparam logic [7:0] IM_RST = 8'hFF, IM_RB = 8'hFF;
`endif

  spi_fifo_master dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .addr(addr), .wdata(wdata), .rdata(rdata),
    .wr(wr), .rd(rd), .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n), .irq(irq)
  );

  always #5 clk = ~clk;
  assign miso = loop_en ? mosi : miso_c;
  always @(posedge sck) sck_pulses++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    ce = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    ce = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    ce = 1'b1; rd = 1'b1; addr = a;
    #1 d = rdata;
    @(posedge clk); #1;
    ce = 1'b0; rd = 1'b0;
  endtask

  task automatic rd_sb(input string nm);
    logic [7:0] d;
    bus_rd(REG_DATA, d);
    if (sb.size() == 0) chk({nm, "_sb_empty"}, 32'(d), 32'h100);
    else                chk(nm, 32'(d), 32'(sb.pop_front()));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
  endtask

  // One byte in loopback; busy must last 16*(DIV+1)+1 sampled cycles with 8 SCK pulses.
  task automatic byte_xfer(input logic [7:0] div, input logic [7:0] b);
    logic [7:0] s;
    int p0, nb;
    bit seen, done;
    bus_wr(REG_DIV, div);
    loop_en = 1'b1;
    p0 = sck_pulses;
    sb.push_back(b);
    bus_wr(REG_DATA, b);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      bus_rd(REG_STATUS, s);
      seen = s[ST_BUSY];
    end
    chk("busy_rise", 32'(seen), 32'd1);
    nb = 1; done = 0;
    for (int i = 0; i < 6000 && !done; i++) begin
      bus_rd(REG_STATUS, s);
      if (s[ST_BUSY]) nb++;
      else done = 1;
    end
    chk("busy_fall", 32'(done), 32'd1);
    chk("byte_time", 32'(nb), 32'(16 * (int'(div) + 1) + 1));
    chk("sck_pulses", 32'(sck_pulses - p0), 32'd8);
    chk("sck_idle", 32'(sck), 32'd0);
    rd_sb("loop_rx");
  endtask

  typedef struct {
    bit         w;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [7:0] s, d;
    int k;

    tbl.push_back('{0, REG_STATUS, 8'h00, 8'h06,   "rst_status"});
    tbl.push_back('{0, REG_DIV,    8'h00, 8'h3F,   "rst_div"});
    tbl.push_back('{0, REG_CS,     8'h00, 8'h00,   "rst_cs"});
    tbl.push_back('{0, REG_IMASK,  8'h00, IM_RST,  "rst_imask"});
    tbl.push_back('{0, 3'd5,       8'h00, 8'hFF,   "reg5"});
    tbl.push_back('{0, 3'd6,       8'h00, 8'hFF,   "reg6"});
    tbl.push_back('{0, 3'd7,       8'h00, 8'hFF,   "reg7"});
    tbl.push_back('{0, REG_DATA,   8'h00, 8'hFF,   "rx_empty_rd"});
    tbl.push_back('{1, REG_DIV,    8'h2A, 8'h00,   ""});
    tbl.push_back('{0, REG_DIV,    8'h00, 8'h2A,   "div_rb"});
    tbl.push_back('{1, REG_IMASK,  8'h05, 8'h00,   ""});
    tbl.push_back('{0, REG_IMASK,  8'h00, IM_RB,   "imask_rb"});
    tbl.push_back('{1, REG_IMASK,  8'h00, 8'h00,   ""});
    tbl.push_back('{1, REG_STATUS, 8'hFF, 8'h00,   ""});
    tbl.push_back('{0, REG_STATUS, 8'h00, 8'h06,   "status_ro"});

    do_reset();
    chk("rst_sck",  32'(sck),  32'd0);
    chk("rst_mosi", 32'(mosi), 32'd1);
    chk("rst_cs_n", 32'(cs_n), 32'h3);
    chk("rst_irq",  32'(irq),  32'd0);
    foreach (tbl[i]) begin
      if (tbl[i].w) bus_wr(tbl[i].a, tbl[i].d);
      else begin
        bus_rd(tbl[i].a, d);
        chk(tbl[i].nm, 32'(d), 32'(tbl[i].exp));
      end
    end

    // Loopback transfers at several divider settings
    byte_xfer(8'd0, 8'hA5);
    byte_xfer(8'd1, 8'h3C);
    byte_xfer(8'd3, 8'h5A);

    // TX overflow: first byte goes straight to the shifter, eight fill TX, tenth drops
    bus_wr(REG_DIV, 8'd63);
    for (int i = 0; i < 10; i++) bus_wr(REG_DATA, 8'(8'h30 + i));
    bus_rd(REG_STATUS, s);
    chk("ovf_status", 32'(s), 32'h55);
    bus_wr(REG_STATUS, 8'h00);
    bus_rd(REG_STATUS, s);
    chk("err_clear", 32'(s), 32'h15);

    // Asynchronous reset in the middle of a byte
    repeat (100) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_sck",  32'(sck),  32'd0);
    chk("abort_mosi", 32'(mosi), 32'd1);
    chk("abort_cs_n", 32'(cs_n), 32'h3);
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    bus_rd(REG_STATUS, s);
    chk("abort_status", 32'(s), 32'h06);
    bus_rd(REG_DIV, s);
    chk("abort_div", 32'(s), 32'h3F);

    // RX full stalls the shifter; one pop lets the ninth byte through
    bus_wr(REG_DIV, 8'd0);
    loop_en = 1'b0; miso_c = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sb.push_back(8'hFF);
      bus_wr(REG_DATA, 8'(i * 7));
    end
    repeat (400) @(posedge clk);
    bus_rd(REG_STATUS, s);
    chk("stall_status", 32'(s), 32'h08);
    rd_sb("stall_rx0");
    repeat (100) @(posedge clk);
    bus_rd(REG_STATUS, s);
    chk("resume_status", 32'(s), 32'h0A);
    for (int i = 0; i < 8; i++) rd_sb("stall_drain");
    bus_rd(REG_DATA, d);
    chk("empty_rd", 32'(d), 32'hFF);
    bus_rd(REG_STATUS, s);
    chk("empty_status", 32'(s), 32'h06);

    // RX push from DONE and CPU pop in the same clock
    loop_en = 1'b1;
    sb.push_back(8'h81);
    bus_wr(REG_DATA, 8'h81);
    repeat (40) @(posedge clk);
    sb.push_back(8'h7E);
    bus_wr(REG_DATA, 8'h7E);
    repeat (17) @(posedge clk);
    rd_sb("same_cyc_pop");
    bus_rd(REG_STATUS, s);
    chk("same_cyc_status", 32'(s), 32'h02);
    rd_sb("same_cyc_next");
    bus_rd(REG_STATUS, s);
    chk("same_cyc_empty", 32'(s), 32'h06);

    // Chip select is deferred until queued bytes finish
    bus_wr(REG_CS, 8'h01);
    bus_rd(REG_STATUS, s);
    chk("cs_pending", 32'(s), 32'h26);
    repeat (2) @(negedge clk);
    chk("cs_first", 32'(cs_n), 32'h2);
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    bus_wr(REG_DATA, 8'h11);
    bus_wr(REG_DATA, 8'h22);
    bus_wr(REG_CS, 8'h02);
    k = 0;
    for (int i = 1; i <= 200 && k == 0; i++) begin
      @(negedge clk);
      if (cs_n == 2'b01) k = i;
      else if (cs_n != 2'b10) k = -i;
    end
    chk("cs_switch_cycle", 32'(k), 32'd36);
    bus_rd(REG_STATUS, s);
    chk("cs_status", 32'(s), 32'h02);
    rd_sb("cs_rx0");
    rd_sb("cs_rx1");

`ifdef SPI_IRQ_EN
    bus_wr(REG_IMASK, 8'h02);
    sb.push_back(8'h42);
    bus_wr(REG_DATA, 8'h42);
    k = 0;
    for (int i = 1; i <= 100 && k == 0; i++) begin
      @(negedge clk);
      if (irq) k = i;
    end
    chk("irq_rise_cycle", 32'(k), 32'd20);
    rd_sb("irq_rx");
    chk("irq_hold", 32'(irq), 32'd1);
    @(posedge clk); #1;
    chk("irq_fall", 32'(irq), 32'd0);
    bus_wr(REG_IMASK, 8'h00);
`else
    bus_wr(REG_IMASK, 8'h07);
    sb.push_back(8'h42);
    bus_wr(REG_DATA, 8'h42);
    repeat (40) @(posedge clk);
    chk("irq_tied", 32'(irq), 32'd0);
    rd_sb("irq_rx");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
